req_arbiter_4: RTL and testbench

REQ_ARBITER_4 -- requirements
Module: req_arbiter_4

---
 rtl/req_arbiter_4.sv | 136 +++++++++++++
 tb/tb_req_arbiter_4.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/req_arbiter_4.sv
// req_arbiter_4: four-line round-robin request arbiter with per-line pending
// counters, sticky overflow flags and a registered one-hot grant that feeds a
// downstream 4-to-2 encoder stage.
module req_arbiter_4 #(
  parameter int unsigned CNT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       ready,
  input  logic       ovf_clr,
  output logic [3:0] o,
  output logic       valid,
  output logic [3:0] ovf
);

  localparam int unsigned NL = 4;  // number of request lines
  localparam int unsigned CW = 4;  // pending counter width
  localparam int unsigned PW = 2;  // line index width

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q [NL];
  logic [CW-1:0]   cnt_d [NL];
  logic [NL-1:0]   ovf_q, ovf_d;
  logic [NL-1:0]   ovf_set_c;
  logic [NL-1:0]   o_q, o_d;
  logic            valid_q, valid_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gidx_q, gidx_d;
  logic            sel_found_c;
  logic [PW-1:0]   sel_idx_c;
  logic            consume_c;

  // Round-robin pick over registered counts: ptr+1, ptr+2, ptr+3, ptr.
  always_comb begin
    logic [PW-1:0] idx;
    sel_found_c = 1'b0;
    sel_idx_c   = '0;
    idx         = '0;
    for (int i = 1; i <= int'(NL); i++) begin
      idx = ptr_q + PW'(i);
      if (!sel_found_c && (cnt_q[idx] != '0)) begin
        sel_found_c = 1'b1;
        sel_idx_c   = idx;
      end
    end
  end

  // Grant FSM next-state and registered-output next values.
  always_comb begin
    state_d   = state_q;
    o_d       = o_q;
    valid_d   = valid_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    consume_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_found_c) begin
          state_d = S_GRANT;
          o_d     = NL'(1) << sel_idx_c;
          valid_d = 1'b1;
          gidx_d  = sel_idx_c;
        end
      end
      S_GRANT: begin
        if (ready) begin
          consume_c = 1'b1;
          ptr_d     = gidx_q;
          state_d   = S_IDLE;
          o_d       = '0;
          valid_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        o_d     = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // Pending counters: request increments (saturating), consume decrements,
  // both together cancel; a request at saturation raises overflow.
  always_comb begin
    ovf_set_c = '0;
    for (int k = 0; k < int'(NL); k++) begin
      cnt_d[k] = cnt_q[k];
      if (req[k] && !(consume_c && (gidx_q == PW'(k)))) begin
        if (cnt_q[k] < CW'(CNT_MAX)) begin
          cnt_d[k] = cnt_q[k] + CW'(1);
        end else begin
          ovf_set_c[k] = 1'b1;
        end
      end else if (!req[k] && consume_c && (gidx_q == PW'(k))) begin
        cnt_d[k] = cnt_q[k] - CW'(1);
      end
    end
    ovf_d = (ovf_q & ~{NL{ovf_clr}}) | ovf_set_c;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      o_q     <= '0;
      valid_q <= 1'b0;
      ovf_q   <= '0;
      ptr_q   <= PW'(NL - 1);
      gidx_q  <= '0;
      for (int k = 0; k < int'(NL); k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      for (int k = 0; k < int'(NL); k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign o     = o_q;
  assign valid = valid_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_req_arbiter_4.sv
// Testbench for req_arbiter_4: table-driven vectors plus hand-written
// multi-cycle sequences, checked through an expected-result queue.
module tb_req_arbiter_4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       ready;
  logic       ovf_clr;
  logic [3:0] o;
  logic       valid;
  logic [3:0] ovf;

  int total;
  int bad;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       ready;
    logic       clr;
    logic [3:0] eo;
    logic       ev;
    logic [3:0] eovf;
  } vec_t;

  typedef struct {
    logic [3:0] eo;
    logic       ev;
    logic [3:0] eovf;
    string      tag;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];

  req_arbiter_4 #(.CNT_MAX(15)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .ready   (ready),
    .ovf_clr (ovf_clr),
    .o       (o),
    .valid   (valid),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream 4-to-2 encoder as seen by the next stage.
  function automatic logic [1:0] enc(input logic [3:0] v);
    logic [1:0] c;
    c = 2'd0;
    if (v[1]) c = 2'd1;
    if (v[2]) c = 2'd2;
    if (v[3]) c = 2'd3;
    return c;
  endfunction

  // Expected code: bit position of the expected one-hot grant.
  function automatic logic [1:0] pos_of(input logic [3:0] v);
    logic [1:0] p;
    p = 2'd0;
    for (int b = 0; b < 4; b++) begin
      if (v[b]) p = 2'(b);
    end
    return p;
  endfunction

  function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic rd,
                              input logic cl, input logic [3:0] eo, input logic ev,
                              input logic [3:0] eovf);
    vec_t v;
    v.rst_n = r; v.req = rq; v.ready = rd; v.clr = cl;
    v.eo = eo; v.ev = ev; v.eovf = eovf;
    return v;
  endfunction

  task automatic check_one();
    exp_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty got 0 entries want 1");
      return;
    end
    e = sb.pop_front();
    total++;
    if (o !== e.eo) begin
      bad++;
      $display("FAIL %s o: got %b want %b", e.tag, o, e.eo);
    end
    total++;
    if (valid !== e.ev) begin
      bad++;
      $display("FAIL %s valid: got %b want %b", e.tag, valid, e.ev);
    end
    total++;
    if (ovf !== e.eovf) begin
      bad++;
      $display("FAIL %s ovf: got %b want %b", e.tag, ovf, e.eovf);
    end
    if (e.ev) begin
      total++;
      if (enc(o) !== pos_of(e.eo)) begin
        bad++;
        $display("FAIL %s enc: got %b want %b", e.tag, enc(o), pos_of(e.eo));
      end
    end
  endtask

  task automatic step(input logic r, input logic [3:0] rq, input logic rd, input logic cl,
                      input logic [3:0] eo, input logic ev, input logic [3:0] eovf,
                      input string tag);
    exp_t e;
    rst_n   = r;
    req     = rq;
    ready   = rd;
    ovf_clr = cl;
    e.eo = eo; e.ev = ev; e.eovf = eovf; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_one();
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    req     = 4'b0000;
    ready   = 1'b0;
    ovf_clr = 1'b0;

    // Single request latency and return to idle.
    tbl.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000));
    tbl.push_back(mk(1'b0, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000));
    tbl.push_back(mk(1'b1, 4'b0100, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000));
    tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0100, 1'b1, 4'b0000));
    tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000));
    tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000));
    tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000));
    // Four lines, one request each, round-robin from line 0.
    tbl.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000));
    tbl.push_back(mk(1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000));
    tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0001, 1'b1, 4'b0000));
    tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000));
    tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0010, 1'b1, 4'b0000));
    tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000));
    tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0100, 1'b1, 4'b0000));
    tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000));
    tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b0, 4'b1000, 1'b1, 4'b0000));
    tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000));
    tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst_n, tbl[i].req, tbl[i].ready, tbl[i].clr,
           tbl[i].eo, tbl[i].ev, tbl[i].eovf, $sformatf("tbl%0d", i));
    end

    // Saturation, overflow, set-wins-over-clear, then drain exactly 15 grants.
    step(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, "sat_rst");
    for (int k = 1; k <= 17; k++) begin
      step(1'b1, 4'b0001, 1'b0, 1'b0,
           (k >= 2) ? 4'b0001 : 4'b0000, (k >= 2),
           (k >= 16) ? 4'b0001 : 4'b0000, $sformatf("sat_req%0d", k));
    end
    step(1'b1, 4'b0001, 1'b0, 1'b1, 4'b0001, 1'b1, 4'b0001, "set_wins");
    step(1'b1, 4'b0000, 1'b0, 1'b1, 4'b0001, 1'b1, 4'b0000, "ovf_clr");
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, $sformatf("drain_c%0d", i));
      step(1'b1, 4'b0000, 1'b1, 1'b0, (i < 14) ? 4'b0001 : 4'b0000, (i < 14), 4'b0000,
           $sformatf("drain_g%0d", i));
    end

    // Stalled grant holds while req toggles; consume with req holds the count.
    step(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, "stall_rst");
    step(1'b1, 4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, "stall_req");
    step(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, 4'b0000, "stall_grant");
    for (int i = 0; i < 5; i++) begin
      step(1'b1, (i % 2 == 0) ? 4'b0010 : 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, 4'b0000,
           $sformatf("stall_hold%0d", i));
    end
    step(1'b1, 4'b0010, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, "stall_consume_req");
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0010, 1'b1, 4'b0000, $sformatf("stall_g%0d", i));
      step(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, $sformatf("stall_c%0d", i));
    end
    step(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, "stall_empty");

    // Reset during a grant with line 3 saturated and overflowed.
    step(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, "rg_rst");
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 4'b1000, 1'b0, 1'b0,
           (k >= 2) ? 4'b1000 : 4'b0000, (k >= 2),
           (k >= 16) ? 4'b1000 : 4'b0000, $sformatf("rg_req%0d", k));
    end
    step(1'b0, 4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0000, "rg_reset_in_grant");
    step(1'b1, 4'b1001, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, "rg_req1001");
    step(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b1, 4'b0000, "rg_first_line0");
    step(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, "rg_consume0");
    step(1'b1, 4'b0000, 1'b1, 1'b0, 4'b1000, 1'b1, 4'b0000, "rg_then_line3");
    step(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, "rg_consume3");
    step(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, "rg_empty");

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got %0d entries want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
